// File: rtl/mips16_pkg.sv
// Shared widths, NOP encoding and IF/ID buffer state encoding.
package mips16_pkg;
  localparam int          DEF_DATA_W    = 32;
  localparam int          DEF_PC_W      = 32;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } buf_state_t;
endpackage

// File: rtl/sat_counter16.sv
// 16-bit saturating accumulator with a 2-bit increment.
// Latency: count updates on the edge after en. Backpressure: none, never wraps.
module sat_counter16 (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        en,
  input  logic [1:0]  inc,
  output logic [15:0] count
);
  logic [15:0] count_q;
  logic [16:0] sum;

  assign sum   = {1'b0, count_q} + {15'd0, inc};
  assign count = count_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 16'd0;
    end else if (en) begin
      count_q <= sum[16] ? 16'hFFFF : sum[15:0];
    end
  end
endmodule

// File: rtl/if_id_buffer.sv
// IF/ID boundary: 2-entry skid buffer between fetch and decode, flush squashes to a NOP bubble.
// Latency: 1 cycle from accept to out_* when EMPTY (or ONE with a consume).
// Backpressure: in_ready drops only in FULL and is decoded from state alone.
module if_id_buffer
  import mips16_pkg::*;
#(
  parameter int                 DATA_W    = DEF_DATA_W,
  parameter int                 PC_W      = DEF_PC_W,
  parameter logic [DATA_W-1:0]  NOP_INSTR = DATA_W'(DEF_NOP_INSTR)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] out_instr,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_valid,
  output logic [1:0]        occupancy,
  output logic [15:0]       drop_count
);
  buf_state_t        state_q, state_d;
  logic [DATA_W-1:0] head_instr_q, skid_instr_q;
  logic [PC_W-1:0]   head_pc_q, skid_pc_q;
  logic              accept, consume;
  logic              load_head, head_from_skid, load_skid, clear_head;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & ~stall;
  assign out_instr = out_valid ? head_instr_q : NOP_INSTR;
  assign out_pc    = head_pc_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    load_head      = 1'b0;
    head_from_skid = 1'b0;
    load_skid      = 1'b0;
    clear_head     = 1'b0;
    if (flush) begin
      state_d    = EMPTY;
      clear_head = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          load_head = 1'b1;
          state_d   = ONE;
        end
        ONE: begin
          if (accept && consume) begin
            load_head = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = FULL;
          end else if (consume) begin
            clear_head = 1'b1;
            state_d    = EMPTY;
          end
        end
        FULL: if (consume) begin
          head_from_skid = 1'b1;
          state_d        = ONE;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // out_pc is left untouched on clear so it holds its last value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_instr_q <= NOP_INSTR;
      head_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      if (load_head) begin
        head_instr_q <= in_instr;
        head_pc_q    <= in_pc;
      end else if (head_from_skid) begin
        head_instr_q <= skid_instr_q;
        head_pc_q    <= skid_pc_q;
      end else if (clear_head) begin
        head_instr_q <= NOP_INSTR;
      end
      if (load_skid) begin
        skid_instr_q <= in_instr;
        skid_pc_q    <= in_pc;
      end
    end
  end

  // A flush squashes every held word plus a word whose handshake completed this cycle.
  sat_counter16 u_drop_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (flush),
    .inc     (state_q + {1'b0, accept}),
    .count   (drop_count)
  );
endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer.
module tb_if_id_buffer;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] in_instr, in_pc;
  logic        in_valid, in_ready, stall, flush;
  logic [31:0] out_instr, out_pc;
  logic        out_valid;
  logic [1:0]  occupancy;
  logic [15:0] drop_count;

  int n_pass = 0;
  int n_chk  = 0;
  int dc_exp = 0;

  always #5 clock = ~clock;

  if_id_buffer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .stall      (stall),
    .flush      (flush),
    .out_instr  (out_instr),
    .out_pc     (out_pc),
    .out_valid  (out_valid),
    .occupancy  (occupancy),
    .drop_count (drop_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic st, input logic fl);
    in_valid = v;
    in_pc    = pc;
    in_instr = 32'hA000_0000 | pc;
    stall    = st;
    flush    = fl;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_occupancy", {30'd0, occupancy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_drop_count", {16'd0, drop_count}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Streaming, no stall.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
      tick();
      chk("stream_out_pc", out_pc, 32'(4 * i));
      chk("stream_out_instr", out_instr, 32'hA000_0000 | 32'(4 * i));
      chk("stream_out_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_occupancy", {30'd0, occupancy}, 32'd1);
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_out_instr", out_instr, 32'd0);

    // Stall fills the skid; third word waits at the input.
    drive(1'b1, 32'd4, 1'b1, 1'b0);
    tick();
    chk("stall_occ1", {30'd0, occupancy}, 32'd1);
    drive(1'b1, 32'd8, 1'b1, 1'b0);
    tick();
    chk("stall_occ2", {30'd0, occupancy}, 32'd2);
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'd12, 1'b1, 1'b0);
    tick();
    chk("stall_hold_occ", {30'd0, occupancy}, 32'd2);
    chk("stall_hold_pc", out_pc, 32'd4);
    drive(1'b1, 32'd12, 1'b0, 1'b0);
    tick();
    chk("release_pc8", out_pc, 32'd8);
    chk("release_occ", {30'd0, occupancy}, 32'd1);
    tick();
    chk("release_pc12", out_pc, 32'd12);
    chk("release_pc12_instr", out_instr, 32'hA000_000C);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    tick();
    chk("release_drained", {30'd0, occupancy}, 32'd0);

    // Flush at occupancy 1 with a completed handshake.
    drive(1'b1, 32'd16, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'd20, 1'b0, 1'b1);
    tick();
    dc_exp += 2;
    chk("flush1_occ", {30'd0, occupancy}, 32'd0);
    chk("flush1_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush1_out_instr", out_instr, 32'd0);
    chk("flush1_drop", {16'd0, drop_count}, 32'(dc_exp));

    // Flush while FULL and stalled; incoming word refused so only 2 drops.
    drive(1'b1, 32'd24, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'd28, 1'b1, 1'b0);
    tick();
    chk("full_occ", {30'd0, occupancy}, 32'd2);
    drive(1'b1, 32'd32, 1'b1, 1'b1);
    tick();
    dc_exp += 2;
    chk("flush2_occ", {30'd0, occupancy}, 32'd0);
    chk("flush2_in_ready", {31'd0, in_ready}, 32'd1);
    chk("flush2_drop", {16'd0, drop_count}, 32'(dc_exp));
    drive(1'b1, 32'd40, 1'b0, 1'b0);
    tick();
    chk("post_flush_pc40", out_pc, 32'd40);
    chk("post_flush_valid", {31'd0, out_valid}, 32'd1);
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    tick();

    // Repeated 2-drop flushes up to and past saturation.
    for (int i = 0; i < 32765; i++) begin
      drive(1'b1, 32'd44, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'd48, 1'b0, 1'b1);
      tick();
      dc_exp += 2;
      if (i == 99) chk("sat_mid", {16'd0, drop_count}, 32'd204);
    end
    chk("sat_fffe", {16'd0, drop_count}, 32'h0000_FFFE);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'd44, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'd48, 1'b0, 1'b1);
      tick();
      chk("sat_ffff", {16'd0, drop_count}, 32'h0000_FFFF);
    end

    // Asynchronous reset mid-cycle with FULL contents.
    drive(1'b1, 32'd52, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'd56, 1'b1, 1'b0);
    tick();
    chk("prereset_occ", {30'd0, occupancy}, 32'd2);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_instr", out_instr, 32'd0);
    chk("async_rst_occ", {30'd0, occupancy}, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("async_rst_drop", {16'd0, drop_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
